// File: rtl/mdu_iter_if.sv
// Handshake/result bundle between the ID/EX stage driver and the iterative MDU.
// master: pipeline side (drives operands); slave: the mdu_iter unit.
interface mdu_iter_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit (shift-add / restoring divide, 32 iterations).
// Optional MDU_FAST_MUL_EN: multiplies bypass the iteration and finish in one cycle.
module mdu_iter (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        launch;
  logic        sgn_a, sgn_b;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [63:0] mul_prod, mul_res;
  logic [31:0] div_lo, div_hi;

  assign launch = bus.start & ~bus.flush & (state_q == StIdle);
  assign sgn_a  = bus.a[31] & ~bus.op[0];
  assign sgn_b  = bus.b[31] & ~bus.op[0];
  assign abs_a  = sgn_a ? -bus.a : bus.a;
  assign abs_b  = sgn_b ? -bus.b : bus.b;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);

  // Divide: acc[31:0] shifts dividend bits out and quotient bits in; borrow means restore.
  assign div_shift = {rem_q, acc_q[31]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_diff[32];

`ifdef MDU_FAST_MUL_EN
  assign mul_prod = {32'd0, opa_q} * {32'd0, opb_q};
`else
  assign mul_prod = acc_q;
`endif
  assign mul_res = (sa_q ^ sb_q) ? -mul_prod : mul_prod;

  // Divide by zero returns all-ones quotient and the original dividend bits.
  assign div_lo = (opb_q == 32'd0) ? 32'hFFFF_FFFF :
                  ((sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0]);
  assign div_hi = (opb_q == 32'd0) ? (sa_q ? -opa_q : opa_q) :
                  (sa_q ? -rem_q : rem_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StCalc;
`ifdef MDU_FAST_MUL_EN
          if (!bus.op[1]) state_d = StSign;
`endif
        end
      end
      StCalc:  if (cnt_q == 5'd31) state_d = StSign;
      StSign:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          op_d  = bus.op;
          sa_d  = sgn_a;
          sb_d  = sgn_b;
          opa_d = abs_a;
          opb_d = abs_b;
          cnt_d = 5'd0;
          rem_d = 32'd0;
          acc_d = {32'd0, bus.op[1] ? abs_a : abs_b};
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[1]) begin
          rem_d = div_ge ? div_diff[31:0] : div_shift[31:0];
          acc_d = {32'd0, acc_q[30:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
      end
      StSign: begin
        done_d = 1'b1;
        if (op_q[1]) begin
          hi_d = div_hi;
          lo_d = div_lo;
        end else begin
          hi_d = mul_res[63:32];
          lo_d = mul_res[31:0];
        end
      end
      default: ;
    endcase
    if (bus.flush) begin
      cnt_d  = 5'd0;
      done_d = 1'b0;
      hi_d   = hi_q;
      lo_d   = lo_q;
    end
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.stall_req = (state_q != StIdle) | (bus.start & ~bus.flush);
    bus.done      = done_q;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mdu_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if bus ();

  mdu_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] last_res;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} as the ISA defines them.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int     ia, ib, q, r;
    longint la, lb;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    case (op)
      2'b00: return la * lb;
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int lat;
    bit got;
    logic [63:0] exp;
    exp = ref_result(op, a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1 check_eq({tag, "_stall_req"}, {63'd0, bus.stall_req}, 64'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check_eq({tag, "_busy_on"}, {63'd0, bus.busy}, 64'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 100 && !got) begin
      if (inject && lat == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      if (inject && lat == 6) bus.start = 1'b0;
      @(posedge clk);
      #1 lat++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_latency"}, 64'(lat), 64'((op[1] == 1'b0) ? MulLat : 33));
      check_eq({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
      check_eq({tag, "_busy_off"}, {63'd0, bus.busy}, 64'd0);
      last_res = exp;
    end
  endtask

  task automatic check_done_drops(input string tag);
    @(posedge clk);
    #1 check_eq({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_done", {63'd0, bus.done}, 64'd0);
    check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("rst_stall", {63'd0, bus.stall_req}, 64'd0);

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    check_done_drops("divu_100_7");
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("mult_m1_3", 2'b00, 32'hFFFF_FFFF, 32'd3, 1'b0);
    check_done_drops("mult_m1_3");
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("start_busy", 2'b11, 32'd100, 32'd7, 1'b1);
    check_done_drops("start_busy");

    // Flush a divide at counter == 10: nothing completes, HI/LO hold.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check_eq("flush_busy", {63'd0, bus.busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done) seen = 1'b1;
    end
    check_eq("flush_no_done", {63'd0, seen}, 64'd0);
    check_eq("flush_hilo", {bus.hi, bus.lo}, last_res);

    // start and flush together never launch.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1 check_eq("sf_stall", {63'd0, bus.stall_req}, 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.flush = 1'b0;
    check_eq("sf_busy", {63'd0, bus.busy}, 64'd0);

    // Back-to-back random ops; each new start lands in the previous done cycle.
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0);
    end

    // Reset in the middle of an operation clears everything.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd1234;
    bus.b     = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check_eq("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("midrst_done", {63'd0, bus.done}, 64'd0);
    check_eq("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done) seen = 1'b1;
    end
    check_eq("midrst_no_done", {63'd0, seen}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
